// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO and one-at-a-time issue sequencer feeding the UART transmitter
// Optional UART_TXQ_OVFCNT_EN adds a saturating dropped-byte counter output ovf_count.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          txq_newd,
  output logic [7:0]    txq_data,
  input  logic          tx_done,
  output logic          busy
`ifdef UART_TXQ_OVFCNT_EN
  ,
  output logic [7:0]    ovf_count
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DRAIN} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_newd;
  logic          w_newd_nxt;
  logic [7:0]    r_data;
  logic [7:0]    w_data_nxt;
  logic          r_overflow;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;

  // Full is judged on start-of-cycle level, so a same-cycle pop never admits a write.
  assign w_full = (r_level == FULL_LVL);
  assign w_push = wr_en && !w_full;
  assign w_drop = wr_en && w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_newd_nxt  = r_newd;
    w_data_nxt  = r_data;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_level != '0) begin
          w_state_nxt = ST_SEND;
          w_newd_nxt  = 1'b1;
          w_data_nxt  = r_mem[r_rd_ptr];
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          w_state_nxt = ST_DRAIN;
          w_newd_nxt  = 1'b0;
          w_pop       = 1'b1;
        end
      end
      ST_DRAIN: begin
        // One done level must be seen to fall before the next byte can be acknowledged.
        if (!tx_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_newd_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_newd     <= 1'b0;
      r_data     <= 8'h00;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_newd     <= w_newd_nxt;
      r_data     <= w_data_nxt;
      r_overflow <= w_drop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

`ifdef UART_TXQ_OVFCNT_EN
  logic [7:0] r_ovf_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_count <= 8'h00;
    end else if (w_drop && (r_ovf_count != 8'hFF)) begin
      r_ovf_count <= r_ovf_count + 8'h01;
    end
  end

  assign ovf_count = r_ovf_count;
`endif

  assign full     = w_full;
  assign empty    = (r_level == '0);
  assign level    = r_level;
  assign overflow = r_overflow;
  assign txq_newd = r_newd;
  assign txq_data = r_data;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - self-checking bench for uart_tx_queue with a queue-based reference model
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        tx_done = 1'b0;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;
  logic        txq_newd;
  logic [7:0]  txq_data;
  logic        busy;
`ifdef UART_TXQ_OVFCNT_EN
  logic [7:0]  ovf_count;
`endif

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .txq_newd (txq_newd),
    .txq_data (txq_data),
    .tx_done  (tx_done),
    .busy     (busy)
`ifdef UART_TXQ_OVFCNT_EN
    ,
    .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue contents plus the issue phase (0 idle, 1 offering, 2 waiting for done low)
  logic [7:0] mq[$];
  int         m_ph = 0;
  logic       m_newd = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ovf = 1'b0;
  int         m_cnt = 0;
  logic [7:0] issued[$];
  int         n_ovf_dut = 0;
  logic       prev_newd = 1'b0;

  initial begin
    logic s_rst, s_we, s_done, m_full, pop;
    logic [7:0] s_d;
    forever begin
      @(posedge clk);
      s_rst = rst; s_we = wr_en; s_d = wr_data; s_done = tx_done;
      if (s_rst) begin
        mq.delete();
        m_ph = 0; m_newd = 1'b0; m_data = 8'h00; m_ovf = 1'b0; m_cnt = 0;
      end else begin
        m_full = (mq.size() == DEPTH);
        m_ovf = s_we && m_full;
        pop = 1'b0;
        if (m_ph == 0) begin
          if (mq.size() != 0) begin
            m_ph = 1; m_newd = 1'b1; m_data = mq[0];
          end
        end else if (m_ph == 1) begin
          if (s_done) begin
            m_ph = 2; m_newd = 1'b0; pop = 1'b1;
          end
        end else if (!s_done) begin
          m_ph = 0;
        end
        if (pop) void'(mq.pop_front());
        if (s_we && !m_full) mq.push_back(s_d);
        if (m_ovf && m_cnt != 255) m_cnt++;
      end
      #1;
      check("mdl_level", 32'(level), mq.size());
      check("mdl_full", 32'(full), 32'(mq.size() == DEPTH));
      check("mdl_empty", 32'(empty), 32'(mq.size() == 0));
      check("mdl_overflow", 32'(overflow), 32'(m_ovf));
      check("mdl_newd", 32'(txq_newd), 32'(m_newd));
      check("mdl_data", 32'(txq_data), 32'(m_data));
      check("mdl_busy", 32'(busy), 32'(m_ph != 0));
`ifdef UART_TXQ_OVFCNT_EN
      check("mdl_ovf_count", 32'(ovf_count), m_cnt);
`endif
      if (txq_newd === 1'b1 && prev_newd !== 1'b1) issued.push_back(txq_data);
      if (overflow === 1'b1) n_ovf_dut++;
      prev_newd = txq_newd;
    end
  end

  task automatic cyc(input logic we, input logic [7:0] d, input logic dn);
    wr_en = we; wr_data = d; tx_done = dn;
    @(negedge clk);
  endtask

  task automatic wait_newd(input string nm);
    int k = 0;
    while (txq_newd !== 1'b1 && k < 20) begin
      cyc(1'b0, 8'h00, 1'b0);
      k++;
    end
    check(nm, 32'(txq_newd), 32'd1);
  endtask

  task automatic ack_one(input string nm);
    wait_newd(nm);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_newd", 32'(txq_newd), 32'd0);
    check("rst_data", 32'(txq_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);

    // single byte, 3-cycle done level
    cyc(1'b1, 8'hA5, 1'b0);
    check("t1_level1", 32'(level), 32'd1);
    check("t1_newd_early", 32'(txq_newd), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    check("t1_newd", 32'(txq_newd), 32'd1);
    check("t1_data", 32'(txq_data), 32'hA5);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    check("t1_newd_low", 32'(txq_newd), 32'd0);
    check("t1_level0", 32'(level), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    check("t1_idle", 32'(busy), 32'd0);

    // issue order
    issued.delete();
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'h0F, 1'b0);
    for (int i = 0; i < 3; i++) ack_one("t2_wait");
    check("t2_count", issued.size(), 32'd3);
    if (issued.size() == 3) begin
      check("t2_b0", 32'(issued[0]), 32'h55);
      check("t2_b1", 32'(issued[1]), 32'hAA);
      check("t2_b2", 32'(issued[2]), 32'h0F);
    end

    // fill past full, then push at full while popping
    issued.delete();
    n_ovf_dut = 0;
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    check("t3_full", 32'(full), 32'd1);
    check("t3_level", 32'(level), 32'd16);
    check("t3_ovf_pulse", 32'(overflow), 32'd1);
    check("t3_ovf_count", n_ovf_dut, 32'd1);
`ifdef UART_TXQ_OVFCNT_EN
    check("t3_ovf_cnt", 32'(ovf_count), 32'd1);
`endif
    cyc(1'b1, 8'hEE, 1'b1);
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_level", 32'(level), 32'd15);
`ifdef UART_TXQ_OVFCNT_EN
    check("t4_ovf_cnt", 32'(ovf_count), 32'd2);
`endif
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 15; i++) ack_one("t4_wait");
    check("t4_issued", issued.size(), 32'd16);
    if (issued.size() == 16) begin
      check("t4_first", 32'(issued[0]), 32'h10);
      check("t4_last", 32'(issued[15]), 32'h1F);
    end
    check("t4_empty", 32'(empty), 32'd1);

    // reset mid-frame
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h41 + i), 1'b0);
    check("t5_sending", 32'(txq_newd), 32'd1);
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    check("t5_newd", 32'(txq_newd), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    rst = 1'b0;
    cyc(1'b1, 8'h77, 1'b0);
    wait_newd("t5_wait");
    check("t5_data", 32'(txq_data), 32'h77);
    ack_one("t5_ack");

    // long done level pops exactly once
    cyc(1'b1, 8'h31, 1'b0);
    cyc(1'b1, 8'h32, 1'b0);
    check("t6_data0", 32'(txq_data), 32'h31);
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1);
    check("t6_level", 32'(level), 32'd1);
    check("t6_newd", 32'(txq_newd), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    check("t6_not_yet", 32'(txq_newd), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    check("t6_newd2", 32'(txq_newd), 32'd1);
    check("t6_data1", 32'(txq_data), 32'h32);
    ack_one("t6_ack");

`ifdef UART_TXQ_OVFCNT_EN
    do_reset();
    for (int i = 0; i < 16 + 300; i++) cyc(1'b1, 8'(i), 1'b0);
    check("t6_ovf_sat", 32'(ovf_count), 32'hFF);
    check("t6_sat_level", 32'(level), 32'd16);
`endif

    cyc(1'b0, 8'h00, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
